// File: rtl/reg_rename_ctrl.sv
// reg_rename_ctrl: register-rename control with busy-bit tracking and a
// post-flush CLEAR/HOLD dispatch stall. Optional statistics counters are
// built only when REG_RENAME_STATS_EN is defined.
module reg_rename_ctrl #(
  parameter int HOLD_CYCLES = 2,
  parameter int TAG_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush_req,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic [4:0]       disp_rd,
  input  logic [TAG_W-1:0] disp_tag,
  input  logic             cmt_valid,
  output logic             cmt_ready,
  input  logic [4:0]       cmt_rd,
  input  logic [TAG_W-1:0] cmt_tag,
  input  logic [31:0]      cmt_data,
  input  logic             rf_cmt_busy,
  input  logic [TAG_W-1:0] rf_cmt_tag,
  output logic             rf_ins_we,
  output logic [4:0]       rf_ins_rd,
  output logic [TAG_W-1:0] rf_ins_tag,
  output logic             rf_cmt_we,
  output logic [4:0]       rf_cmt_rd,
  output logic [31:0]      rf_cmt_data,
  output logic             rf_cmt_clr,
  output logic             rf_clear,
  output logic [31:0]      busy_vec,
  output logic [5:0]       busy_cnt,
  output logic [31:0]      stat_rename,
  output logic [31:0]      stat_stall
);

  localparam logic [3:0] HOLD_INIT = HOLD_CYCLES[3:0];

  typedef enum logic [1:0] {IDLE, CLEAR, HOLD} state_t;

  state_t      state, state_nx;
  logic [3:0]  hold_cnt, hold_cnt_nx;
  logic        en;
  logic        disp_fire, cmt_fire;
  logic [31:0] busy_nx;
  logic [5:0]  cnt_nx;

  // Reset suppresses every strobe in its own cycle, so fold it into the enable.
  assign en = rdy & ~rst;

  // State register; rdy low freezes state and the hold counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
    end else if (rdy) begin
      state    <= state_nx;
      hold_cnt <= hold_cnt_nx;
    end
  end

  // Next-state logic and handshake/strobe outputs.
  always_comb begin
    state_nx    = state;
    hold_cnt_nx = hold_cnt;
    disp_ready  = 1'b0;
    cmt_ready   = 1'b0;
    rf_clear    = 1'b0;
    disp_fire   = 1'b0;
    cmt_fire    = 1'b0;
    rf_ins_we   = 1'b0;
    rf_cmt_we   = 1'b0;
    rf_cmt_clr  = 1'b0;
    rf_ins_rd   = disp_rd;
    rf_ins_tag  = disp_tag;
    rf_cmt_rd   = cmt_rd;
    rf_cmt_data = cmt_data;

    if (flush_req) begin
      state_nx    = CLEAR;
      hold_cnt_nx = '0;
    end else begin
      unique case (state)
        IDLE: ;
        CLEAR: begin
          if (HOLD_INIT != '0) begin
            state_nx    = HOLD;
            hold_cnt_nx = HOLD_INIT;
          end else begin
            state_nx    = IDLE;
            hold_cnt_nx = '0;
          end
        end
        HOLD: begin
          if (hold_cnt <= 4'd1) begin
            state_nx    = IDLE;
            hold_cnt_nx = '0;
          end else begin
            hold_cnt_nx = hold_cnt - 4'd1;
          end
        end
        default: begin
          state_nx    = IDLE;
          hold_cnt_nx = '0;
        end
      endcase
    end

    disp_ready = en & (state == IDLE) & ~flush_req;
    cmt_ready  = en & (state != CLEAR);
    rf_clear   = en & (state == CLEAR);
    disp_fire  = disp_valid & disp_ready;
    cmt_fire   = cmt_valid & cmt_ready;
    rf_ins_we  = disp_fire & (disp_rd != 5'd0);
    rf_cmt_we  = cmt_fire & (cmt_rd != 5'd0);
    // A same-cycle rename of the committing register keeps it busy.
    rf_cmt_clr = rf_cmt_we & rf_cmt_busy & (rf_cmt_tag == cmt_tag) & ~flush_req
               & ~(rf_ins_we & (disp_rd == cmt_rd));
  end

  // Shadow busy bitmap next value and its population count.
  always_comb begin
    busy_nx = busy_vec;
    if (state == CLEAR) begin
      busy_nx = '0;
    end else begin
      if (rf_ins_we)  busy_nx[disp_rd] = 1'b1;
      if (rf_cmt_clr) busy_nx[cmt_rd]  = 1'b0;
    end
    busy_nx[0] = 1'b0;
    cnt_nx = '0;
    for (int unsigned i = 0; i < 32; i++) cnt_nx = cnt_nx + {5'd0, busy_nx[i]};
  end

  // Busy bitmap and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_vec <= '0;
      busy_cnt <= '0;
    end else if (rdy) begin
      busy_vec <= busy_nx;
      busy_cnt <= cnt_nx;
    end
  end

`ifdef REG_RENAME_STATS_EN
  // Free-running rename and stall counters; flush does not clear them.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_rename <= '0;
      stat_stall  <= '0;
    end else if (rdy) begin
      if (rf_ins_we)                 stat_rename <= stat_rename + 32'd1;
      if (disp_valid & ~disp_ready)  stat_stall  <= stat_stall + 32'd1;
    end
  end
`else
  assign stat_rename = '0;
  assign stat_stall  = '0;
`endif

endmodule

// File: tb/tb_reg_rename_ctrl.sv
// Self-checking bench for reg_rename_ctrl: directed scenarios followed by
// randomized traffic, all compared against a sequence-position model.
module tb_reg_rename_ctrl;
  localparam int HOLD = 2;
`ifdef REG_RENAME_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, rdy, flush_req, disp_valid, cmt_valid, rf_cmt_busy;
  logic [4:0]  disp_rd, cmt_rd;
  logic [3:0]  disp_tag, cmt_tag, rf_cmt_tag;
  logic [31:0] cmt_data;
  logic        disp_ready, cmt_ready, rf_ins_we, rf_cmt_we, rf_cmt_clr, rf_clear;
  logic [4:0]  rf_ins_rd, rf_cmt_rd;
  logic [3:0]  rf_ins_tag;
  logic [31:0] rf_cmt_data, busy_vec, stat_rename, stat_stall;
  logic [5:0]  busy_cnt;

  int compared = 0;
  int mismatched = 0;

  // Model: m_rem counts the remaining cycles of the post-flush sequence
  // (HOLD+1 means the clearing cycle, 0 means dispatch is open).
  int          m_rem;
  logic [31:0] m_busy, m_ren, m_stall;
  logic [3:0]  m_tag [32];

  reg_rename_ctrl #(.HOLD_CYCLES(HOLD), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush_req(flush_req),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_rd(disp_rd), .disp_tag(disp_tag),
    .cmt_valid(cmt_valid), .cmt_ready(cmt_ready), .cmt_rd(cmt_rd), .cmt_tag(cmt_tag),
    .cmt_data(cmt_data), .rf_cmt_busy(rf_cmt_busy), .rf_cmt_tag(rf_cmt_tag),
    .rf_ins_we(rf_ins_we), .rf_ins_rd(rf_ins_rd), .rf_ins_tag(rf_ins_tag),
    .rf_cmt_we(rf_cmt_we), .rf_cmt_rd(rf_cmt_rd), .rf_cmt_data(rf_cmt_data),
    .rf_cmt_clr(rf_cmt_clr), .rf_clear(rf_clear), .busy_vec(busy_vec), .busy_cnt(busy_cnt),
    .stat_rename(stat_rename), .stat_stall(stat_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check combinational outputs, clock, check state.
  task automatic step(input logic r, input logic rd_y, input logic fl,
                      input logic dv, input logic [4:0] drd, input logic [3:0] dtag,
                      input logic cv, input logic [4:0] crd, input logic [3:0] ctag,
                      input logic [31:0] cdata, input logic rb, input logic [3:0] rtag);
    logic en, idle, clearing, e_dr, e_cr, e_iw, e_cw, e_clr;
    rst = r; rdy = rd_y; flush_req = fl;
    disp_valid = dv; disp_rd = drd; disp_tag = dtag;
    cmt_valid = cv; cmt_rd = crd; cmt_tag = ctag; cmt_data = cdata;
    rf_cmt_busy = rb; rf_cmt_tag = rtag;
    #1;
    en       = rd_y && !r;
    idle     = (m_rem == 0);
    clearing = (m_rem == HOLD + 1);
    e_dr  = en && idle && !fl;
    e_cr  = en && !clearing;
    e_iw  = dv && e_dr && drd != 0;
    e_cw  = cv && e_cr && crd != 0;
    e_clr = e_cw && rb && rtag == ctag && !fl && !(e_iw && drd == crd);
    check("disp_ready", {31'd0, disp_ready}, {31'd0, e_dr});
    check("cmt_ready",  {31'd0, cmt_ready},  {31'd0, e_cr});
    check("rf_ins_we",  {31'd0, rf_ins_we},  {31'd0, e_iw});
    check("rf_ins_rd",  {27'd0, rf_ins_rd},  {27'd0, drd});
    check("rf_ins_tag", {28'd0, rf_ins_tag}, {28'd0, dtag});
    check("rf_cmt_we",  {31'd0, rf_cmt_we},  {31'd0, e_cw});
    check("rf_cmt_rd",  {27'd0, rf_cmt_rd},  {27'd0, crd});
    check("rf_cmt_data", rf_cmt_data, cdata);
    check("rf_cmt_clr", {31'd0, rf_cmt_clr}, {31'd0, e_clr});
    check("rf_clear",   {31'd0, rf_clear},   {31'd0, en && clearing});
    @(posedge clk);
    if (r) begin
      m_rem = 0; m_busy = '0; m_ren = '0; m_stall = '0;
    end else if (rd_y) begin
      if (clearing) m_busy = '0;
      else begin
        if (e_iw)  begin m_busy[drd] = 1'b1; m_tag[drd] = dtag; end
        if (e_clr) m_busy[crd] = 1'b0;
      end
      if (e_iw) m_ren++;
      if (dv && !e_dr) m_stall++;
      if (fl) m_rem = HOLD + 1;
      else if (m_rem > 0) m_rem--;
    end
    #1;
    check("busy_vec", busy_vec, m_busy);
    check("busy_cnt", {26'd0, busy_cnt}, $countones(m_busy));
    check("stat_rename", stat_rename, STATS ? m_ren : 32'd0);
    check("stat_stall",  stat_stall,  STATS ? m_stall : 32'd0);
  endtask

  task automatic idle_step(input logic dv);
    step(0, 1, 0, dv, 5'd1, 4'd0, 0, 5'd0, 4'd0, 32'd0, 0, 4'd0);
  endtask

  initial begin
    m_rem = 0; m_busy = '0; m_ren = '0; m_stall = '0;
    for (int i = 0; i < 32; i++) m_tag[i] = '0;

    // Reset, with junk traffic and a flush that reset must override.
    step(1, 1, 1, 1, 5'd7, 4'd2, 1, 5'd7, 4'd2, 32'h1234, 1, 4'd2);
    step(1, 0, 0, 0, 5'd0, 4'd0, 0, 5'd0, 4'd0, 32'd0, 0, 4'd0);
    check("reset_busy_cnt", {26'd0, busy_cnt}, 32'd0);

    // Rename x5 with tag 3.
    step(0, 1, 0, 1, 5'd5, 4'd3, 0, 5'd0, 4'd0, 32'd0, 0, 4'd0);
    check("ren5_busy5", {31'd0, busy_vec[5]}, 32'd1);
    check("ren5_cnt", {26'd0, busy_cnt}, 32'd1);
    // Matching commit frees x5.
    step(0, 1, 0, 0, 5'd0, 4'd0, 1, 5'd5, 4'd3, 32'hdead_beef, 1, 4'd3);
    check("cmt5_cnt", {26'd0, busy_cnt}, 32'd0);
    // Stale-tag commit leaves x5 busy.
    step(0, 1, 0, 1, 5'd5, 4'd3, 0, 5'd0, 4'd0, 32'd0, 0, 4'd0);
    step(0, 1, 0, 0, 5'd0, 4'd0, 1, 5'd5, 4'd3, 32'h55, 1, 4'd7);
    check("stale_busy5", {31'd0, busy_vec[5]}, 32'd1);

    // Same-cycle rename and commit of x9: rename wins.
    step(0, 1, 0, 1, 5'd9, 4'd4, 0, 5'd0, 4'd0, 32'd0, 0, 4'd0);
    step(0, 1, 0, 1, 5'd9, 4'd5, 1, 5'd9, 4'd4, 32'h99, 1, 4'd4);
    check("same_busy9", {31'd0, busy_vec[9]}, 32'd1);

    // x0 is never renamed or written.
    step(0, 1, 0, 1, 5'd0, 4'd6, 1, 5'd0, 4'd6, 32'h77, 1, 4'd6);
    check("x0_busy0", {31'd0, busy_vec[0]}, 32'd0);

    // Flush: stall during flush, CLEAR and two HOLD cycles.
    step(0, 1, 1, 1, 5'd3, 4'd1, 0, 5'd0, 4'd0, 32'd0, 0, 4'd0);
    idle_step(1);
    check("post_clear_busy", busy_vec, 32'd0);
    idle_step(1);
    idle_step(1);
    idle_step(1);

    // rdy low mid-HOLD stretches HOLD.
    step(0, 1, 1, 0, 5'd0, 4'd0, 0, 5'd0, 4'd0, 32'd0, 0, 4'd0);
    idle_step(1);
    idle_step(1);
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 1, 5'd2, 4'd2, 1, 5'd5, 4'd3, 32'd1, 1, 4'd3);
    idle_step(1);
    idle_step(1);

    // Flush restarted inside HOLD, then reset mid-sequence.
    step(0, 1, 1, 0, 5'd0, 4'd0, 0, 5'd0, 4'd0, 32'd0, 0, 4'd0);
    idle_step(0);
    step(0, 1, 1, 1, 5'd4, 4'd4, 0, 5'd0, 4'd0, 32'd0, 0, 4'd0);
    step(1, 1, 0, 1, 5'd4, 4'd4, 0, 5'd0, 4'd0, 32'd0, 0, 4'd0);
    idle_step(1);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      logic [4:0] drd, crd;
      logic [3:0] ctag, rtag;
      logic rb;
      drd  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      crd  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      rb   = ($urandom_range(0, 4) != 0) ? m_busy[crd] : 1'($urandom);
      rtag = ($urandom_range(0, 4) != 0) ? m_tag[crd] : 4'($urandom);
      ctag = ($urandom_range(0, 3) != 0) ? m_tag[crd] : 4'($urandom);
      step(($urandom_range(0, 79) == 0), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 24) == 0), 1'($urandom), drd, 4'($urandom),
           1'($urandom), crd, ctag, $urandom, rb, rtag);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
